// File: rtl/shift_mux_arbiter_pkg.sv
// Shared types and constants for the shift/mux arbiter slice.
package shift_mux_arb_pkg;

    // Output register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Source tags reported on out_src
    localparam logic SRC_REQ0 = 1'b0;
    localparam logic SRC_REQ1 = 1'b1;

    // Default left-shift applied to requester-0 data
    localparam int DEFAULT_SHIFT = 3;

endpackage : shift_mux_arb_pkg

// File: rtl/shift_mux_arbiter_datapath.sv
// Combinational shared datapath: requester-0 operand is shifted left,
// requester-1 operand passes through, and the arbiter's select picks one.
module shift_mux_datapath
    import shift_mux_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHIFT = DEFAULT_SHIFT
) (
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             sel,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] shifted;

    // Shift truncates to WIDTH; bits shifted past the MSB are discarded
    assign shifted = data0 << SHIFT;

    // 2:1 select between shifted and pass-through operands
    always_comb begin
        result = shifted;
        if (sel == SRC_REQ1) begin
            result = data1;
        end
    end

endmodule : shift_mux_datapath

// File: rtl/shift_mux_arbiter.sv
// Round-robin arbiter sharing one shift/mux datapath between two
// valid/ready requesters, feeding a one-entry registered output stage.
module shift_mux_arbiter
    import shift_mux_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHIFT = DEFAULT_SHIFT,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    state_t           state;
    logic             last_grant;
    logic             winner;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] mux_result;

    // Counter increment that sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Slot is free when empty, or when the held result leaves this cycle
    assign can_accept = (state == EMPTY) | (out_ready & out_valid);
    assign out_valid  = (state == FULL);

    // Round-robin pick: a lone requester wins; on contention the one not granted last wins
    always_comb begin
        winner = SRC_REQ0;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else if (req1_valid) begin
            winner = SRC_REQ1;
        end
    end

    assign req0_ready = can_accept & req0_valid & (winner == SRC_REQ0);
    assign req1_ready = can_accept & req1_valid & (winner == SRC_REQ1);
    assign accept     = req0_ready | req1_ready;

    shift_mux_datapath #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_datapath (
        .data0  (req0_data),
        .data1  (req1_data),
        .sel    (winner),
        .result (mux_result)
    );

    // Occupancy FSM, output register, round-robin history and grant counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_src    <= SRC_REQ0;
            last_grant <= SRC_REQ1;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            state      <= FULL;
            out_data   <= mux_result;
            out_src    <= winner;
            last_grant <= winner;
            if (winner == SRC_REQ0) begin
                grant_cnt0 <= sat_inc(grant_cnt0);
            end else begin
                grant_cnt1 <= sat_inc(grant_cnt1);
            end
        end else if (state == FULL && out_ready) begin
            state <= EMPTY;
        end
    end

endmodule : shift_mux_arbiter
